// File: rtl/piped_adder.sv
// piped_adder: pipelined binary adder tree summing N_args signed addends,
// one register stage per tree level, with an optional aligned valid delay line.
module piped_adder #(
    parameter int N_args = 9,
    parameter int arg_width = 4,
    parameter bit dis_valid = 1'b0,
    localparam int H = $clog2(N_args)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_args*arg_width-1:0]       args_in,
    input  logic                              we,
    output logic signed [arg_width+H-1:0]     sum_out,
    output logic                              valid
);
    for (genvar k = 0; k <= H; k++) begin : st
        localparam int C = (N_args + (1 << k) - 1) >> k;
        logic signed [arg_width+k-1:0] v [C];
        if (k == 0) begin : leaf
            for (genvar i = 0; i < C; i++) begin : a
                assign v[i] = args_in[i*arg_width +: arg_width];
            end
        end else begin : node
            localparam int P = (N_args + (1 << (k - 1)) - 1) >> (k - 1);
            localparam int M = arg_width + k - 2;
            for (genvar i = 0; i < C; i++) begin : n
                logic signed [arg_width+k-1:0] r;
                logic [arg_width+k-1:0] lo;
                assign lo = {st[k-1].v[2*i][M], st[k-1].v[2*i]};
                // An odd leftover element is only widened, keeping every path equally deep
                if (2*i + 1 < P) begin : add
                    logic [arg_width+k-1:0] hi;
                    assign hi = {st[k-1].v[2*i+1][M], st[k-1].v[2*i+1]};
                    always_ff @(posedge clk or posedge reset)
                        if (reset) r <= '0;
                        else r <= lo + hi;
                end else begin : pass
                    always_ff @(posedge clk or posedge reset)
                        if (reset) r <= '0;
                        else r <= lo;
                end
                assign v[i] = r;
            end
        end
    end
    assign sum_out = st[H].v[0];
    if (dis_valid) begin : comb
        assign valid = we;
    end else begin : dly
        logic [H-1:0] vd;
        always_ff @(posedge clk or posedge reset)
            if (reset) vd <= '0;
            else vd <= H'({vd, we});
        assign valid = vd[H-1];
    end
endmodule

// File: tb/tb_piped_adder.sv
// tb_piped_adder: scoreboard bench for piped_adder in 9-, 2- and 3-addend
// configurations plus a combinational-valid instance.
module tb_piped_adder;
    typedef struct {
        int s;
        int t;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic we;
    logic [35:0] args;
    logic signed [7:0] s9, sd;
    logic signed [4:0] s2;
    logic signed [5:0] s3;
    logic v9, v2, v3, vd;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n9 = 0;
    int base;
    exp_t q9[$], q2[$], q3[$];
    exp_t e;
    logic [63:0] rnd;

    piped_adder u9 (.clk(clk), .reset(reset), .args_in(args), .we(we), .sum_out(s9), .valid(v9));
    piped_adder #(.N_args(2)) u2 (.clk(clk), .reset(reset), .args_in(args[7:0]), .we(we), .sum_out(s2), .valid(v2));
    piped_adder #(.N_args(3)) u3 (.clk(clk), .reset(reset), .args_in(args[11:0]), .we(we), .sum_out(s3), .valid(v3));
    piped_adder #(.dis_valid(1'b1)) ud (.clk(clk), .reset(reset), .args_in(args), .we(we), .sum_out(sd), .valid(vd));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int model(input logic [35:0] a, input int n);
        int s = 0;
        logic signed [3:0] x;
        for (int i = 0; i < n; i++) begin
            x = a[i*4 +: 4];
            s += int'(x);
        end
        return s;
    endfunction

    task automatic drive(input logic w, input logic [35:0] a);
        @(posedge clk);
        #1;
        we = w;
        args = a;
        if (w) begin
            q9.push_back('{model(a, 9), cyc + 4});
            q2.push_back('{model(a, 2), cyc + 1});
            q3.push_back('{model(a, 3), cyc + 2});
        end
    endtask

    always @(negedge clk) begin
        check("valid_comb", int'(vd), int'(we));
        if (v9) begin
            n9++;
            if (q9.size() == 0) check("stale9", 1, 0);
            else begin
                e = q9.pop_front();
                check("sum9", int'(s9), e.s);
                check("lat9", cyc, e.t);
            end
        end
        if (v2) begin
            if (q2.size() == 0) check("stale2", 1, 0);
            else begin
                e = q2.pop_front();
                check("sum2", int'(s2), e.s);
                check("lat2", cyc, e.t);
            end
        end
        if (v3) begin
            if (q3.size() == 0) check("stale3", 1, 0);
            else begin
                e = q3.pop_front();
                check("sum3", int'(s3), e.s);
                check("lat3", cyc, e.t);
            end
        end
    end

    initial begin
        reset = 1'b1;
        we = 1'b0;
        args = '0;
        #12;
        check("rst_sum9", int'(s9), 0);
        check("rst_valid9", int'(v9), 0);
        check("rst_sum2", int'(s2), 0);
        check("rst_sum3", int'(s3), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        base = n9;
        drive(1'b1, 36'h777777777);
        drive(1'b1, 36'h777777777);
        repeat (7) drive(1'b0, '0);
        check("pulse_len9", n9 - base, 2);
        drive(1'b1, 36'h888888888);
        drive(1'b1, 36'hE5D3F0187);
        repeat (6) drive(1'b0, '0);
        base = n9;
        for (int i = 0; i < 50; i++) begin
            rnd = {$urandom(), $urandom()};
            drive(1'b1, rnd[35:0]);
        end
        repeat (6) drive(1'b0, '0);
        check("stream_count9", n9 - base, 50);
        drive(1'b1, 36'h777777777);
        drive(1'b1, 36'hE5D3F0187);
        drive(1'b0, '0);
        #2;
        reset = 1'b1;
        we = 1'b1;
        q9.delete();
        q2.delete();
        q3.delete();
        #1;
        check("async_sum9", int'(s9), 0);
        check("async_valid9", int'(v9), 0);
        check("async_sum2", int'(s2), 0);
        check("async_sum3", int'(s3), 0);
        @(posedge clk);
        #1;
        we = 1'b0;
        reset = 1'b0;
        base = n9;
        repeat (8) drive(1'b0, '0);
        check("no_stale9", n9 - base, 0);
        drive(1'b1, 36'hE5D3F0187);
        repeat (6) drive(1'b0, '0);
        check("drain9", q9.size(), 0);
        check("drain2", q2.size(), 0);
        check("drain3", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piped_adder.md
PIPED_ADDER -- requirements
Module: piped_adder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: one clock; reset is asynchronous and active-high.
REQ-002 Parameter N_args, default 9, SHALL set the number of signed addends; legal range 2..65536/arg_width (total input bus at most 65536 bits).
REQ-003 Parameter arg_width, default 4, SHALL set the bits per addend (two's complement), legal range 1..32.
REQ-004 Parameter dis_valid, default 0, SHALL control valid: 0 = valid is we delayed by the pipeline latency, 1 = valid is we passed through combinationally.
REQ-005 Derived constant H = ceil(log2(N_args)) SHALL be the tree height.
REQ-006 Port clk, input, 1 bit: rising-edge clock for all registers.
REQ-007 Port reset, input, 1 bit: asynchronous active-high clear of all registers.
REQ-008 Port args_in, input, N_args*arg_width bits: addend i occupies bits [(i+1)*arg_width-1 : i*arg_width], signed.
REQ-009 Port we, input, 1 bit: input-valid qualifier.
REQ-010 Port sum_out, output, arg_width+H bits, signed: sum of all addends.
REQ-011 Port valid, output, 1 bit: qualifies sum_out (see REQ-017).

Function
REQ-012 The adder SHALL be a binary tree of H register stages; stage k (1..H) SHALL add adjacent pairs of stage k-1 results, with stage 0 being the addends.
REQ-013 Each stage-k operand SHALL be sign-extended by 1 bit before addition, so stage-k results are arg_width+k bits wide.
REQ-014 When a stage has an odd element count, the last element SHALL pass through that stage, sign-extended by 1 bit and registered, with no addition, so that all paths have equal latency.
REQ-015 sum_out SHALL equal the exact signed sum of the addends sampled H rising edges earlier; overflow cannot occur at this width and SHALL NOT be handled.
REQ-016 The data pipeline SHALL be free-running: it SHALL register on every clock regardless of we, with no stall or enable input.
REQ-017 With dis_valid=0, valid SHALL be we delayed through an H-deep shift register aligned with the data path; with dis_valid=1, valid SHALL equal we combinationally.
REQ-018 A we pulse of length L cycles SHALL produce a valid pulse of length L cycles; back-to-back inputs SHALL be accepted every cycle (throughput 1 sum/clk).
REQ-019 sum_out SHALL be driven directly from the final stage register, with no output combinational logic.

Reset
REQ-020 Asserting reset SHALL immediately, without waiting for a clock edge, clear every tree register (sum_out = 0) and every valid-delay register (valid = 0 when dis_valid=0).
REQ-021 Reset asserted mid-operation SHALL discard all in-flight sums and valid bits, with nothing emitted afterwards for them; after reset is released, new inputs SHALL appear H cycles after sampling.
REQ-022 With dis_valid=1, valid SHALL follow we even during reset.

Verification
REQ-023 N_args=9, arg_width=4 (H=4, sum_out 8 bits), all addends +7, we held high 2 cycles -> sum_out=63 after 4 rising edges, and valid high for exactly 2 cycles starting 4 cycles after we.
REQ-024 Same configuration, all addends -8 -> sum_out=-72 (0xB8); addends {7,-8,1,0,-1,3,-3,5,-2} -> sum_out=2 after 4 edges.
REQ-025 Streaming test: change args_in every cycle with random values for 50 cycles -> each sum_out matches the software sum of the inputs 4 cycles earlier, with no gaps.
REQ-026 Reset pulse asserted while valid is in flight -> sum_out=0 and valid=0 asynchronously, and no stale valid appears after reset is released.
REQ-027 N_args=2, arg_width=4, addends (-8,-8) -> sum_out=-16 (5 bits) after 1 edge; N_args=3 addends (7,7,7) -> 21 after 2 edges, exercising the odd-element pass-through.
REQ-028 dis_valid=1 -> valid equals we on every cycle, including during reset.
